rename_free_list_mp: RTL and testbench



---
 rtl/rename_free_list_mp_if.sv | 41 ++++
 rtl/rename_free_list_mp.sv | 122 ++++++++++++
 tb/tb_rename_free_list_mp.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rename_free_list_mp_if.sv
// Rename free-list bus: the allocation, release, commit and flush signals
// exchanged between the rename/commit logic (master) and the free list (slave).
//   alloc_req    thermometer-coded allocation request, one bit per port
//   alloc_grant  every requested port is served this cycle
//   alloc_preg   physical register offered on each allocation port
//   free_valid   per-port release strobe, any pattern
//   free_preg    register released on each free port
//   commit_valid allocations retired this cycle
//   flush        restore the speculative head to the committed head
//   free_count   number of allocatable entries
//   empty        free_count is zero
interface rename_free_list_mp_if #(
    parameter int unsigned PHYS_REGS   = 64,
    parameter int unsigned ARCH_REGS   = 32,
    parameter int unsigned ALLOC_PORTS = 2,
    parameter int unsigned FREE_PORTS  = 2
);
    localparam int unsigned DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int unsigned PW    = $clog2(PHYS_REGS);
    localparam int unsigned AW    = $clog2(DEPTH);

    logic [ALLOC_PORTS-1:0]         alloc_req;
    logic                           alloc_grant;
    logic [ALLOC_PORTS-1:0][PW-1:0] alloc_preg;
    logic [FREE_PORTS-1:0]          free_valid;
    logic [FREE_PORTS-1:0][PW-1:0]  free_preg;
    logic [ALLOC_PORTS-1:0]         commit_valid;
    logic                           flush;
    logic [AW:0]                    free_count;
    logic                           empty;

    modport master (
        output alloc_req, free_valid, free_preg, commit_valid, flush,
        input  alloc_grant, alloc_preg, free_count, empty
    );

    modport slave (
        input  alloc_req, free_valid, free_preg, commit_valid, flush,
        output alloc_grant, alloc_preg, free_count, empty
    );
endinterface

// File: rtl/rename_free_list_mp.sv
// Multi-port physical-register free list for the rename stage.
// Circular buffer of DEPTH register numbers with a speculative head, a
// committed head (chead) and a tail. Up to ALLOC_PORTS registers leave per
// cycle (all-or-nothing), up to FREE_PORTS enter per cycle, and a flush
// rewinds head to the post-commit chead in one cycle.
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  rename_free_list_mp_if slave modport (alloc/free/commit/flush/status)
module rename_free_list_mp #(
    parameter int unsigned PHYS_REGS   = 64,
    parameter int unsigned ARCH_REGS   = 32,
    parameter int unsigned ALLOC_PORTS = 2,
    parameter int unsigned FREE_PORTS  = 2
) (
    input logic                   clk,
    input logic                   rst,
    rename_free_list_mp_if.slave  bus
);
    localparam int unsigned DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int unsigned PW    = $clog2(PHYS_REGS);
    localparam int unsigned AW    = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [AW:0] ptr_t;

    logic [PW-1:0]  mem_q [DEPTH];
    ptr_t           head_q, head_d;
    ptr_t           chead_q, chead_d;
    ptr_t           tail_q, tail_d;
    ptr_t           n_alloc, n_free, n_commit;
    ptr_t           free_count;
    logic           grant;
    logic [AW-1:0]  free_off [FREE_PORTS];

    // Port popcounts; free_off is the compacted slot of each valid free port.
    always_comb begin
        n_alloc  = '0;
        n_free   = '0;
        n_commit = '0;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            n_alloc  = n_alloc + ptr_t'(bus.alloc_req[i]);
            n_commit = n_commit + ptr_t'(bus.commit_valid[i]);
        end
        for (int p = 0; p < FREE_PORTS; p++) begin
            free_off[p] = n_free[AW-1:0];
            n_free      = n_free + ptr_t'(bus.free_valid[p]);
        end
    end

    always_comb begin
        free_count = tail_q - head_q;
        grant      = (n_alloc != '0) && (free_count >= n_alloc) && !bus.flush;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            bus.alloc_preg[i] = mem_q[head_q[AW-1:0] + AW'(i)];
        end
        bus.alloc_grant = grant;
        bus.free_count  = free_count;
        bus.empty       = (free_count == '0);
    end

    // Flush restores head to the committed head including this cycle's commits.
    always_comb begin
        chead_d = chead_q + n_commit;
        tail_d  = tail_q + n_free;
        head_d  = head_q;
        if (bus.flush) begin
            head_d = chead_d;
        end else if (grant) begin
            head_d = head_q + n_alloc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            chead_q <= '0;
            tail_q  <= ptr_t'(DEPTH);
        end else begin
            head_q  <= head_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
        end
    end

    // Released registers become visible to allocation only from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PW'(ARCH_REGS + i);
            end
        end else begin
            for (int p = 0; p < FREE_PORTS; p++) begin
                if (bus.free_valid[p]) begin
                    mem_q[tail_q[AW-1:0] + free_off[p]] <= bus.free_preg[p];
                end
            end
        end
    end

    // Illegal usage checks; the datapath does not guard against these.
    logic [ALLOC_PORTS-1:0] req_p1;
    logic [AW+1:0]          occupancy;
    ptr_t                   in_flight;

    always_comb begin
        req_p1    = bus.alloc_req + ALLOC_PORTS'(1);
        occupancy = {1'b0, ptr_t'(tail_q - chead_q)} + {1'b0, n_free};
        in_flight = head_q - chead_q;
    end

    a_req_thermo: assert property (@(posedge clk) disable iff (rst)
        ((bus.alloc_req & req_p1) == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (occupancy <= (AW+2)'(DEPTH)));
    a_commit_le_head: assert property (@(posedge clk) disable iff (rst)
        (n_commit <= in_flight));

    for (genvar p = 0; p < FREE_PORTS; p++) begin : g_free_chk
        a_free_not_arch: assert property (@(posedge clk) disable iff (rst)
            (bus.free_valid[p] |-> (bus.free_preg[p] >= PW'(ARCH_REGS))));
    end
endmodule

// File: tb/tb_rename_free_list_mp.sv
module tb_rename_free_list_mp;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    rename_free_list_mp_if #(
        .PHYS_REGS(64), .ARCH_REGS(32), .ALLOC_PORTS(2), .FREE_PORTS(2)
    ) bus ();

    rename_free_list_mp #(
        .PHYS_REGS(64), .ARCH_REGS(32), .ALLOC_PORTS(2), .FREE_PORTS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_req    = '0;
        bus.free_valid   = '0;
        bus.free_preg    = '0;
        bus.commit_valid = '0;
        bus.flush        = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " free_count"}, bus.free_count, 32);
        check({tag, " empty"}, bus.empty, 0);
        check({tag, " grant"}, bus.alloc_grant, 0);
        check({tag, " preg0"}, bus.alloc_preg[0], 32);
        check({tag, " preg1"}, bus.alloc_preg[1], 33);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        idle_inputs();

        // 1: reset then idle
        do_reset();
        check_reset_state("s1");
        cyc();
        check_reset_state("s1 idle");

        // 2: drain all 32 entries two at a time
        for (int c = 0; c < 16; c++) begin
            bus.alloc_req = 2'b11;
            #1;
            check($sformatf("s2 grant c%0d", c), bus.alloc_grant, 1);
            check($sformatf("s2 preg0 c%0d", c), bus.alloc_preg[0], 32 + 2 * c);
            check($sformatf("s2 preg1 c%0d", c), bus.alloc_preg[1], 33 + 2 * c);
            cyc();
        end
        bus.alloc_req = 2'b00;
        #1;
        check("s2 free_count drained", bus.free_count, 0);
        check("s2 empty drained", bus.empty, 1);
        bus.alloc_req = 2'b11;
        #1;
        check("s2 grant 11 empty", bus.alloc_grant, 0);
        bus.alloc_req = 2'b01;
        #1;
        check("s2 grant 01 empty", bus.alloc_grant, 0);
        cyc();
        bus.alloc_req = 2'b00;
        #1;
        check("s2 head held", bus.alloc_preg[0], 32);
        check("s2 free_count held", bus.free_count, 0);

        // Retire the 32 allocations so the list has room for releases.
        bus.commit_valid = 2'b11;
        for (int c = 0; c < 16; c++) cyc();
        bus.commit_valid = 2'b00;

        // 4: sparse free at tail index 0, then allocate back in order
        bus.free_valid   = 2'b10;
        bus.free_preg[1] = 6'd40;
        bus.free_preg[0] = 6'd33;
        cyc();
        bus.free_valid   = 2'b11;
        bus.free_preg[0] = 6'd44;
        bus.free_preg[1] = 6'd45;
        cyc();
        idle_inputs();
        #1;
        check("s4 free_count", bus.free_count, 3);
        check("s4 mem0", bus.alloc_preg[0], 40);
        check("s4 mem1", bus.alloc_preg[1], 44);
        bus.alloc_req = 2'b11;
        #1;
        check("s4 grant 11", bus.alloc_grant, 1);
        cyc();
        bus.alloc_req = 2'b01;
        #1;
        check("s4 grant 01", bus.alloc_grant, 1);
        check("s4 mem2", bus.alloc_preg[0], 45);
        cyc();
        bus.alloc_req = 2'b00;
        #1;
        check("s4 free_count after", bus.free_count, 0);

        // 3: partial availability with one entry
        bus.free_valid   = 2'b01;
        bus.free_preg[0] = 6'd50;
        cyc();
        idle_inputs();
        #1;
        check("s3 free_count 1", bus.free_count, 1);
        bus.alloc_req = 2'b11;
        #1;
        check("s3 grant 11", bus.alloc_grant, 0);
        bus.alloc_req = 2'b01;
        #1;
        check("s3 grant 01", bus.alloc_grant, 1);
        check("s3 preg0", bus.alloc_preg[0], 50);
        cyc();
        bus.alloc_req = 2'b00;
        #1;
        check("s3 free_count 0", bus.free_count, 0);
        check("s3 empty", bus.empty, 1);

        // 5: allocate four, commit two, flush
        do_reset();
        bus.alloc_req = 2'b11;
        cyc();
        cyc();
        bus.alloc_req    = 2'b00;
        bus.commit_valid = 2'b11;
        #1;
        check("s5 free_count 28", bus.free_count, 28);
        cyc();
        bus.commit_valid = 2'b00;
        bus.flush        = 1'b1;
        bus.alloc_req    = 2'b11;
        #1;
        check("s5 grant in flush", bus.alloc_grant, 0);
        cyc();
        bus.flush = 1'b0;
        #1;
        check("s5 free_count 30", bus.free_count, 30);
        check("s5 grant after", bus.alloc_grant, 1);
        check("s5 preg0", bus.alloc_preg[0], 34);
        check("s5 preg1", bus.alloc_preg[1], 35);

        // 6: head=4 chead=2; flush with one commit and one free
        cyc();
        bus.alloc_req    = 2'b00;
        bus.flush        = 1'b1;
        bus.commit_valid = 2'b01;
        bus.free_valid   = 2'b01;
        bus.free_preg[0] = 6'd33;
        cyc();
        idle_inputs();
        #1;
        check("s6 free_count", bus.free_count, 30);
        check("s6 head preg0", bus.alloc_preg[0], 35);
        check("s6 head preg1", bus.alloc_preg[1], 36);
        bus.alloc_req = 2'b11;
        cyc();
        cyc();
        #2;
        // Between edges: reset must take effect without a clock.
        rst           = 1'b1;
        bus.alloc_req = 2'b00;
        #1;
        check_reset_state("s6 async rst");
        cyc();
        rst           = 1'b0;
        bus.alloc_req = 2'b11;
        #1;
        check("s6 first grant", bus.alloc_grant, 1);
        check("s6 first preg0", bus.alloc_preg[0], 32);
        check("s6 first preg1", bus.alloc_preg[1], 33);
        cyc();
        bus.alloc_req = 2'b00;
        #1;
        check("s6 free_count post", bus.free_count, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
